life_grid: RTL and testbench
============================

# life_grid

Parametrised Game-of-Life grid engine. It holds a ROWS×COLS array of cells and advances the whole array one generation per update, using programmable birth/survival rules and selectable edge handling. Updates come from single-step pulses or from a free-running, period-divided run mode that can auto-halt when the pattern becomes stable. It sits between the pattern loader and the display/readout logic, replacing a set of individual per-cell state machines.

## Interface
- ROWS, 16, grid height (≥3)
- COLS, 16, grid width (≥3)
- WRAP, 1, 1 = toroidal edges; 0 = out-of-grid neighbours count as dead
- HALT_ON_STABLE, 1, 1 = run mode stops when an update changes no cell
- GEN_W, 16, generation counter width
- DIV_W, 24, period/divider width
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- load  in  1  parallel load of init_grid
- init_grid  in  ROWS*COLS  initial pattern; cell (r,c) at bit r*COLS+c
- birth_mask  in  9  bit n set: a dead cell with n live neighbours becomes alive (Conway = 9'h008)
- survive_mask  in  9  bit n set: a live cell with n live neighbours stays alive (Conway = 9'h00C)
- run  in  1  level; free-running mode request
- step  in  1  single-generation request, honoured only in IDLE
- period  in  DIV_W  cycles per generation in RUN; 0 treated as 1
- grid  out  ROWS*COLS  current cell states, same bit mapping
- generation  out  GEN_W  generations since load/reset, wraps modulo 2^GEN_W
- gen_tick  out  1  high for the one cycle after each update
- stable  out  1  last update changed no cell
- extinct  out  1  grid == 0 (decoded from the grid register)
- halted  out  1  state == HALT

## Operation
- Next-state function, per cell: n = live-neighbour count (0..8) over the 8-neighbourhood. Wrap is modulo ROWS/COLS when WRAP=1; otherwise missing neighbours count as 0. next = cell ? survive_mask[n] : birth_mask[n]. Rule masks are sampled at the update edge.
- An update writes the next state to every cell, increments generation, sets gen_tick, and sets stable = (next == grid).
- FSM states:
  - IDLE: if step is high, update at this edge (held high for k cycles gives k updates). If run is high, go to RUN and clear cnt. run takes priority over step in the same cycle; that cycle does no update.
  - RUN: if run is low, go to IDLE with no update. Else if cnt ≥ max(period,1)−1, update and clear cnt. Else increment cnt. If HALT_ON_STABLE is set and the update is stable, go to HALT.
  - HALT: no updates; step is ignored; run low returns to IDLE.
- Priority at each edge: reset > load > update.
- load, in any state: grid ← init_grid, generation ← 0, stable ← 0, gen_tick ← 0, cnt ← 0, state ← IDLE. If run is still high, RUN is entered on the next edge.
- period changes mid-run take effect immediately. The ≥ compare guarantees an update on the next edge if cnt already exceeds the new limit.

## Timing
- Reset values: grid 0, generation 0, gen_tick 0, stable 0, extinct 1, halted 0, state IDLE, cnt 0.
- Reset is asynchronous: outputs change without waiting for clk, including mid-RUN. Release is synchronous to the next clk edge.
- Step latency: with step high before edge E, grid holds the new generation after E, and gen_tick is high for the cycle E→E+1.
- RUN cadence: if RUN is entered at edge E0, updates occur at E0+P, E0+2P, … where P = max(period,1). With P=1 the grid updates every cycle and gen_tick stays high continuously.
- HALT is entered at the same edge as the stable update. halted rises with gen_tick.
- generation wraps from 2^GEN_W−1 to 0 with no flag.
- extinct is combinational from grid: valid in the same cycle as grid, with no extra latency.

## Test plan
- ROWS=COLS=5, WRAP=0, Conway rules. Load a vertical blinker at (1,2),(2,2),(3,2), then step. Expect a horizontal blinker at (2,1),(2,2),(2,3), generation=1, a 1-cycle gen_tick, stable=0. Step again: the vertical pattern returns, generation=2.
- Load a 2×2 block at (1,1), then run=1 with period=3. Expect the first update exactly 3 edges after RUN entry, with stable=1 and halted=1. No further gen_tick while run stays high. Drop run: halted=0.
- 8×8, WRAP=1, glider at (0,1),(1,2),(2,0),(2,1),(2,2). Run with period=1 for 32 generations. Expect grid == initial pattern, generation=32, stable=0 throughout.
- Set birth_mask=0 and survive_mask=0 with any nonzero pattern, then step. Expect grid=0 and extinct=1. A further step gives stable=1 and generation=2.
- Assert load in the same cycle as a RUN update. Expect grid=init_grid, generation=0, no gen_tick. With run still high, the next update occurs P edges after RUN is re-entered.
- Assert reset asynchronously mid-RUN, between edges. Expect grid=0, generation=0, halted=0 and extinct=1 before the next clk edge.

Source files
------------

// File: rtl/life_grid.sv
// Game-of-Life grid engine: whole-array next-state logic, step/run/halt control,
// generation counter and stability/extinction status.
module life_grid #(
   parameter int ROWS           = 16,
   parameter int COLS           = 16,
   parameter int WRAP           = 1,
   parameter int HALT_ON_STABLE = 1,
   parameter int GEN_W          = 16,
   parameter int DIV_W          = 24
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic [ROWS*COLS-1:0]   init_grid,
   input  logic [8:0]             birth_mask,
   input  logic [8:0]             survive_mask,
   input  logic                   run,
   input  logic                   step,
   input  logic [DIV_W-1:0]       period,
   output logic [ROWS*COLS-1:0]   grid,
   output logic [GEN_W-1:0]       generation,
   output logic                   gen_tick,
   output logic                   stable,
   output logic                   extinct,
   output logic                   halted
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

   state_t                 r_state, w_state_next;
   logic [ROWS*COLS-1:0]   r_grid;
   logic [ROWS*COLS-1:0]   w_next;
   logic [GEN_W-1:0]       r_gen;
   logic [DIV_W-1:0]       r_cnt, w_cnt_next, w_limit;
   logic                   r_tick, r_stable;
   logic                   w_update, w_same;

   function automatic logic [3:0] pop9(input logic [8:0] v);
      logic [3:0] s;
      s = '0;
      for (int k = 0; k < 9; k++) s = s + {3'b000, v[k]};
      return s;
   endfunction

   // Neighbour taps are resolved at elaboration; off-grid taps tie to 0 unless wrapping.
   genvar gi, gk;
   generate
      for (gi = 0; gi < ROWS*COLS; gi++) begin : g_cell
         localparam int R = gi / COLS;
         localparam int C = gi % COLS;
         logic [8:0] w_nb;
         logic [3:0] w_n;
         for (gk = 0; gk < 9; gk++) begin : g_nb
            localparam int  RR     = R + gk / 3 - 1;
            localparam int  CC     = C + gk % 3 - 1;
            localparam bit  INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
            localparam int  IDX    = ((RR + ROWS) % ROWS) * COLS + ((CC + COLS) % COLS);
            if (gk == 4) begin : g_self
               assign w_nb[gk] = 1'b0;
            end else if (WRAP != 0 || INSIDE) begin : g_tap
               assign w_nb[gk] = r_grid[IDX];
            end else begin : g_edge
               assign w_nb[gk] = 1'b0;
            end
         end
         assign w_n        = pop9(w_nb);
         assign w_next[gi] = r_grid[gi] ? survive_mask[w_n] : birth_mask[w_n];
      end
   endgenerate

   assign w_same  = (w_next == r_grid);
   assign w_limit = (period == '0) ? '0 : period - {{(DIV_W-1){1'b0}}, 1'b1};

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_update     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (run) begin
               w_state_next = ST_RUN;
               w_cnt_next   = '0;
            end else if (step) begin
               w_update = 1'b1;
            end
         end
         ST_RUN: begin
            if (!run) begin
               w_state_next = ST_IDLE;
            end else if (r_cnt >= w_limit) begin
               w_update   = 1'b1;
               w_cnt_next = '0;
               if (HALT_ON_STABLE != 0 && w_same) w_state_next = ST_HALT;
            end else begin
               w_cnt_next = r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
            end
         end
         ST_HALT: begin
            if (!run) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_grid   <= '0;
         r_gen    <= '0;
         r_cnt    <= '0;
         r_tick   <= 1'b0;
         r_stable <= 1'b0;
      end else if (load) begin
         r_state  <= ST_IDLE;
         r_grid   <= init_grid;
         r_gen    <= '0;
         r_cnt    <= '0;
         r_tick   <= 1'b0;
         r_stable <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_tick  <= w_update;
         if (w_update) begin
            r_grid   <= w_next;
            r_gen    <= r_gen + {{(GEN_W-1){1'b0}}, 1'b1};
            r_stable <= w_same;
         end
      end
   end

   assign grid       = r_grid;
   assign generation = r_gen;
   assign gen_tick   = r_tick;
   assign stable     = r_stable;
   assign extinct    = (r_grid == '0);
   assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_life_grid.sv
// Bench for life_grid: a 5x5 bounded grid and an 8x8 toroidal grid, with
// per-update expectations queued by stimulus and checked by tick monitors.
module tb_life_grid;

   typedef struct {
      logic [63:0] grid;
      logic        chk_grid;
      logic [15:0] gen;
      logic        stable;
      logic        halted;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 5x5, bounded edges
   logic        a_load, a_run, a_step;
   logic [24:0] a_init, a_grid;
   logic [8:0]  a_birth, a_surv;
   logic [23:0] a_period;
   logic [15:0] a_gen;
   logic        a_tick, a_stable, a_extinct, a_halted;

   // 8x8, toroidal edges
   logic        b_load, b_run, b_step;
   logic [63:0] b_init, b_grid;
   logic [23:0] b_period;
   logic [15:0] b_gen;
   logic        b_tick, b_stable, b_extinct, b_halted;

   life_grid #(.ROWS(5), .COLS(5), .WRAP(0), .HALT_ON_STABLE(1), .GEN_W(16), .DIV_W(24)) u_a (
      .clk(clk), .reset(reset), .load(a_load), .init_grid(a_init),
      .birth_mask(a_birth), .survive_mask(a_surv), .run(a_run), .step(a_step),
      .period(a_period), .grid(a_grid), .generation(a_gen), .gen_tick(a_tick),
      .stable(a_stable), .extinct(a_extinct), .halted(a_halted));

   life_grid #(.ROWS(8), .COLS(8), .WRAP(1), .HALT_ON_STABLE(1), .GEN_W(16), .DIV_W(24)) u_b (
      .clk(clk), .reset(reset), .load(b_load), .init_grid(b_init),
      .birth_mask(9'h008), .survive_mask(9'h00C), .run(b_run), .step(b_step),
      .period(b_period), .grid(b_grid), .generation(b_gen), .gen_tick(b_tick),
      .stable(b_stable), .extinct(b_extinct), .halted(b_halted));

   localparam logic [24:0] VBL = (25'd1 << 7) | (25'd1 << 12) | (25'd1 << 17);
   localparam logic [24:0] HBL = (25'd1 << 11) | (25'd1 << 12) | (25'd1 << 13);
   localparam logic [24:0] BLK = (25'd1 << 6) | (25'd1 << 7) | (25'd1 << 11) | (25'd1 << 12);
   localparam logic [63:0] GLD = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) | (64'd1 << 17) | (64'd1 << 18);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_a(input logic [24:0] g, input int gen, input logic st, input logic h);
      exp_t e;
      e.grid = {39'd0, g}; e.chk_grid = 1'b1; e.gen = 16'(gen); e.stable = st; e.halted = h;
      qa.push_back(e);
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (a_tick) begin
         if (qa.size() == 0) begin
            check("a_unexpected_tick", {48'd0, a_gen}, 64'hFFFF);
         end else begin
            exp_t e;
            e = qa.pop_front();
            $display("A update gen=%0d grid=%07h stable=%0b halted=%0b", a_gen, a_grid, a_stable, a_halted);
            check("a_grid", {39'd0, a_grid}, e.grid);
            check("a_gen", {48'd0, a_gen}, {48'd0, e.gen});
            check("a_stable", {63'd0, a_stable}, {63'd0, e.stable});
            check("a_halted", {63'd0, a_halted}, {63'd0, e.halted});
         end
      end
   end

   always @(negedge clk) begin
      if (b_tick) begin
         if (qb.size() == 0) begin
            check("b_unexpected_tick", {48'd0, b_gen}, 64'hFFFF);
         end else begin
            exp_t e;
            e = qb.pop_front();
            $display("B update gen=%0d grid=%016h stable=%0b", b_gen, b_grid, b_stable);
            if (e.chk_grid) check("b_grid", b_grid, e.grid);
            check("b_gen", {48'd0, b_gen}, {48'd0, e.gen});
            check("b_stable", {63'd0, b_stable}, {63'd0, e.stable});
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      a_load = 0; a_run = 0; a_step = 0; a_init = '0; a_birth = 9'h008; a_surv = 9'h00C; a_period = 24'd1;
      b_load = 0; b_run = 0; b_step = 0; b_init = '0; b_period = 24'd1;
      edge1(); edge1();
      reset = 1'b0;
      edge1();
      check("rst_grid", {39'd0, a_grid}, 64'd0);
      check("rst_gen", {48'd0, a_gen}, 64'd0);
      check("rst_tick", {63'd0, a_tick}, 64'd0);
      check("rst_stable", {63'd0, a_stable}, 64'd0);
      check("rst_extinct", {63'd0, a_extinct}, 64'd1);
      check("rst_halted", {63'd0, a_halted}, 64'd0);

      // Blinker, single steps
      a_init = VBL; a_load = 1; edge1(); a_load = 0;
      check("load_grid", {39'd0, a_grid}, {39'd0, VBL});
      push_a(HBL, 1, 1'b0, 1'b0);
      a_step = 1; edge1(); a_step = 0;
      edge1();
      check("step_tick_1cycle", {63'd0, a_tick}, 64'd0);
      push_a(VBL, 2, 1'b0, 1'b0);
      a_step = 1; edge1(); a_step = 0;
      edge1();

      // Block: first update 3 edges after RUN entry, then halt
      a_init = BLK; a_load = 1; edge1(); a_load = 0;
      a_period = 24'd3; a_run = 1;
      edge1();
      push_a(BLK, 1, 1'b1, 1'b1);
      edge1(); check("run_p3_e1", {63'd0, a_tick}, 64'd0);
      edge1(); check("run_p3_e2", {63'd0, a_tick}, 64'd0);
      edge1(); check("run_p3_e3", {63'd0, a_tick}, 64'd1);
      a_step = 1;
      repeat (8) edge1();
      check("halt_held", {63'd0, a_halted}, 64'd1);
      check("halt_gen", {48'd0, a_gen}, 64'd1);
      a_run = 0; a_step = 0; edge1();
      check("halt_release", {63'd0, a_halted}, 64'd0);

      // Zero rules: extinction then a stable empty update
      a_init = VBL; a_load = 1; edge1(); a_load = 0;
      a_birth = 9'h000; a_surv = 9'h000;
      push_a(25'd0, 1, 1'b0, 1'b0);
      a_step = 1; edge1(); a_step = 0;
      check("extinct", {63'd0, a_extinct}, 64'd1);
      push_a(25'd0, 2, 1'b1, 1'b0);
      a_step = 1; edge1(); a_step = 0;
      edge1();
      a_birth = 9'h008; a_surv = 9'h00C;

      // Load collides with a RUN update
      a_init = VBL; a_load = 1; edge1(); a_load = 0;
      a_period = 24'd2; a_run = 1;
      edge1();
      edge1();
      a_init = HBL; a_load = 1; edge1(); a_load = 0;
      check("ld_coll_grid", {39'd0, a_grid}, {39'd0, HBL});
      check("ld_coll_gen", {48'd0, a_gen}, 64'd0);
      check("ld_coll_tick", {63'd0, a_tick}, 64'd0);
      edge1();
      push_a(VBL, 1, 1'b0, 1'b0);
      edge1(); check("ld_reentry_e1", {63'd0, a_tick}, 64'd0);
      edge1(); check("ld_reentry_e2", {63'd0, a_tick}, 64'd1);
      a_run = 0; edge1(); edge1();

      // Toroidal glider, 32 generations at period 1
      b_init = GLD; b_load = 1; edge1(); b_load = 0;
      for (int i = 1; i <= 32; i++) begin
         exp_t e;
         e.grid = GLD; e.chk_grid = (i == 32); e.gen = 16'(i); e.stable = 1'b0; e.halted = 1'b0;
         qb.push_back(e);
      end
      b_run = 1; edge1();
      repeat (32) @(posedge clk);
      #1 b_run = 0;
      edge1(); edge1();
      check("glider_grid", b_grid, GLD);
      check("glider_gen", {48'd0, b_gen}, 64'd32);

      // Asynchronous reset between edges mid-RUN
      a_init = VBL; a_load = 1; edge1(); a_load = 0;
      a_period = 24'd1;
      push_a(HBL, 1, 1'b0, 1'b0);
      push_a(VBL, 2, 1'b0, 1'b0);
      a_run = 1; edge1();
      edge1(); edge1();
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      check("arst_grid", {39'd0, a_grid}, 64'd0);
      check("arst_gen", {48'd0, a_gen}, 64'd0);
      check("arst_halted", {63'd0, a_halted}, 64'd0);
      check("arst_extinct", {63'd0, a_extinct}, 64'd1);
      check("arst_tick", {63'd0, a_tick}, 64'd0);
      a_run = 0;
      edge1();
      reset = 1'b0;
      edge1(); edge1();

      check("qa_drained", 64'(qa.size()), 64'd0);
      check("qb_drained", 64'(qb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
